// File: rtl/encoder_8_to_3_drain_pkg.sv
// Shared types and sizing for the 8:3 draining encoder.
// Optional round-robin selection is enabled with the ENC_RR_EN macro.
package enc_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned IDXW  = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  // True when exactly one bit of v is set
  function automatic logic is_one_hot(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/encoder_8_to_3_drain_if.sv
// Request-vector input stream and index output stream of the draining encoder.
// The slave modport is the encoder side; master is the source/consumer side.
interface encoder_8_to_3_drain_if #(
  parameter int unsigned WIDTH = enc_pkg::WIDTH,
  parameter int unsigned IDXW  = enc_pkg::IDXW
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDXW-1:0]  out_idx;
  logic             out_last;

  modport slave (
    input  in_valid,
    input  in_vec,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_idx,
    output out_last
  );

  modport master (
    output in_valid,
    output in_vec,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_idx,
    input  out_last
  );

endinterface

// File: rtl/encoder_8_to_3_drain_penc_sel.sv
// Combinational pending-bit selector: fixed MSB-first priority by default,
// downward round-robin search from ptr (with wrap) when ENC_RR_EN is defined.
module penc_sel
  import enc_pkg::*;
#(
  parameter int unsigned WIDTH = enc_pkg::WIDTH,
  parameter int unsigned IDXW  = enc_pkg::IDXW
) (
  input  logic [WIDTH-1:0] pend,
`ifdef ENC_RR_EN
  input  logic [IDXW-1:0]  ptr,
`endif
  output logic [IDXW-1:0]  idx,
  output logic             one_hot
);

  logic [IDXW-1:0] pos;
  logic            found;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
`ifdef ENC_RR_EN
      // Index arithmetic wraps naturally because WIDTH is a power of two
      pos = ptr - IDXW'(k);
`else
      pos = IDXW'(WIDTH - 1 - k);
`endif
      if (!found && pend[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
  end

  assign one_hot = is_one_hot(pend);

endmodule

// File: rtl/encoder_8_to_3_drain.sv
// Registered 8:3 encoder that drains every set bit of an accepted request
// vector as one index per handshake. ENC_RR_EN selects round-robin order.
module encoder_8_to_3_drain
  import enc_pkg::*;
#(
  parameter int unsigned WIDTH = enc_pkg::WIDTH,
  parameter int unsigned IDXW  = enc_pkg::IDXW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  encoder_8_to_3_drain_if.slave  bus,
  output logic                   zero_err,
  output logic                   busy
);

  state_t           state;
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] pend_next;
  logic             accept;
  logic             take;
  logic [IDXW-1:0]  sel_idx;
  logic             sel_last;

  assign bus.in_ready = (state == IDLE);
  assign accept       = bus.in_valid && (state == IDLE);
  assign take         = bus.out_valid && bus.out_ready;

  // The selector looks at next-cycle pending bits so out_idx/out_last can be registered
  always_comb begin
    pend_next = pend;
    if (accept) begin
      pend_next = bus.in_vec;
    end else if (take) begin
      pend_next = pend & ~(WIDTH'(1) << bus.out_idx);
    end
  end

`ifdef ENC_RR_EN
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] ptr_next;

  assign ptr_next = take ? (bus.out_idx - 1'b1) : ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= IDXW'(WIDTH - 1);
    end else begin
      ptr <= ptr_next;
    end
  end

  penc_sel #(.WIDTH(WIDTH), .IDXW(IDXW)) u_sel (
    .pend    (pend_next),
    .ptr     (ptr_next),
    .idx     (sel_idx),
    .one_hot (sel_last)
  );
`else
  penc_sel #(.WIDTH(WIDTH), .IDXW(IDXW)) u_sel (
    .pend    (pend_next),
    .idx     (sel_idx),
    .one_hot (sel_last)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pend          <= '0;
      bus.out_valid <= 1'b0;
      bus.out_idx   <= '0;
      bus.out_last  <= 1'b0;
      zero_err      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      pend         <= pend_next;
      bus.out_idx  <= sel_idx;
      bus.out_last <= sel_last;
      zero_err     <= accept && (bus.in_vec == '0);
      case (state)
        IDLE: begin
          if (accept && (bus.in_vec != '0)) begin
            state         <= DRAIN;
            bus.out_valid <= 1'b1;
            busy          <= 1'b1;
          end
        end
        DRAIN: begin
          if (take && bus.out_last) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_8_to_3_drain.sv
// Self-checking bench for encoder_8_to_3_drain; honours ENC_RR_EN when defined.
module tb_encoder_8_to_3_drain;
  import enc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic zero_err;
  logic busy;

  int checks   = 0;
  int failures = 0;
  int unsigned mptr;
  int seen[$];

  always #5 clk = ~clk;

  encoder_8_to_3_drain_if #(.WIDTH(WIDTH), .IDXW(IDXW)) bus ();

  encoder_8_to_3_drain #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .zero_err (zero_err),
    .busy     (busy)
  );

  // Reference selection: scan downward from a start point, wrapping past 0
  function automatic int ref_pick(input logic [7:0] p, input int unsigned ptr);
    int unsigned start;
`ifdef ENC_RR_EN
    start = ptr;
`else
    start = WIDTH - 1;
`endif
    for (int unsigned k = 0; k < WIDTH; k++) begin
      if (p[(start + WIDTH - k) % WIDTH]) return int'((start + WIDTH - k) % WIDTH);
    end
    return -1;
  endfunction

  task automatic reset_dut();
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_vec = 8'($urandom);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mptr = WIDTH - 1;
  endtask

  // Offer one vector and drain it, checking every output cycle against the model
  task automatic run_vec(input logic [7:0] vec, input int stall_pct);
    logic [7:0] p;
    logic [7:0] dec;
    int exp;
    int n;
    p = vec;
    seen.delete();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL in_ready_before got=%b want=1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_vec = vec;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_vec = 8'($urandom);
    if (vec == 8'h00) begin
      checks++;
      if (zero_err !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL zero_pulse got zero_err=%b out_valid=%b busy=%b want 1,0,0", zero_err, bus.out_valid, busy);
      end
      @(posedge clk); #1;
      checks++;
      if (zero_err !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL zero_after got zero_err=%b in_ready=%b out_valid=%b want 0,1,0", zero_err, bus.in_ready, bus.out_valid);
      end
      return;
    end
    n = 0;
    while (p != 8'h00 && n < 200) begin
      n++;
      exp = ref_pick(p, mptr);
      bus.out_ready = ($urandom_range(99) >= stall_pct);
      dec = 8'h01 << bus.out_idx;
      checks++;
      if (bus.out_valid !== 1'b1 || busy !== 1'b1 || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL drain_flags got out_valid=%b busy=%b in_ready=%b want 1,1,0", bus.out_valid, busy, bus.in_ready);
      end
      checks++;
      if (bus.out_idx !== IDXW'(exp)) begin
        failures++; $display("FAIL out_idx vec=%h got=%0d want=%0d", vec, bus.out_idx, exp);
      end
      checks++;
      if (bus.out_last !== ($countones(p) == 1)) begin
        failures++; $display("FAIL out_last vec=%h got=%b want=%b", vec, bus.out_last, ($countones(p) == 1));
      end
      checks++;
      if ((dec & vec) == 8'h00) begin
        failures++; $display("FAIL round_trip vec=%h got idx=%0d want a set bit", vec, bus.out_idx);
      end
      @(posedge clk); #1;
      if (bus.out_ready) begin
        p[exp] = 1'b0;
        seen.push_back(exp);
        mptr = (exp + WIDTH - 1) % WIDTH;
      end
    end
    bus.out_ready = 1'b0;
    checks++;
    if (n >= 200) begin
      failures++; $display("FAIL drain_timeout vec=%h got %0d cycles want <200", vec, n);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL drain_end got out_valid=%b in_ready=%b busy=%b want 0,1,0", bus.out_valid, bus.in_ready, busy);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_idx !== '0 || bus.out_last !== 1'b0 ||
        zero_err !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state got v=%b idx=%0d last=%b zerr=%b busy=%b rdy=%b want 0,0,0,0,0,1",
               bus.out_valid, bus.out_idx, bus.out_last, zero_err, busy, bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_vec = 8'hA1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_idx !== '0 || bus.out_last !== 1'b0 ||
        busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_async got v=%b idx=%0d last=%b busy=%b rdy=%b want 0,0,0,0,1",
               bus.out_valid, bus.out_idx, bus.out_last, busy, bus.in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mptr = WIDTH - 1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_release got rdy=%b v=%b want 1,0", bus.in_ready, bus.out_valid);
    end
    run_vec(8'h81, 0);
    checks++;
    if (seen.size() != 2 || seen[0] != 7 || seen[1] != 0) begin
      failures++; $display("FAIL reset_discard got n=%0d first=%0d want 2 indices 7,0", seen.size(), seen.size() > 0 ? seen[0] : -1);
    end
  endtask

  task automatic test_single_bit();
    reset_dut();
    run_vec(8'b0000_1000, 0);
    checks++;
    if (seen.size() != 1 || seen[0] != 3) begin
      failures++; $display("FAIL single_bit got n=%0d want one index 3", seen.size());
    end
  endtask

  task automatic test_multi_bit();
    reset_dut();
    run_vec(8'b1010_0001, 0);
    checks++;
    if (seen.size() != 3 || seen[0] != 7 || seen[1] != 5 || seen[2] != 0) begin
      failures++; $display("FAIL multi_bit got n=%0d want sequence 7,5,0", seen.size());
    end
  endtask

  task automatic test_stall();
    reset_dut();
    bus.in_valid = 1'b1;
    bus.in_vec = 8'b0110_0000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'd6 || bus.out_last !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got v=%b idx=%0d last=%b want 1,6,0", i, bus.out_valid, bus.out_idx, bus.out_last);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    checks++;
    if (bus.out_idx !== 3'd6 || bus.out_last !== 1'b0) begin
      failures++; $display("FAIL stall_first got idx=%0d last=%b want 6,0", bus.out_idx, bus.out_last);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'd5 || bus.out_last !== 1'b1) begin
      failures++; $display("FAIL stall_second got v=%b idx=%0d last=%b want 1,5,1", bus.out_valid, bus.out_idx, bus.out_last);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    mptr = 4;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL stall_end got v=%b rdy=%b want 0,1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_zero_vec();
    reset_dut();
    run_vec(8'h00, 0);
    run_vec(8'h10, 0);
    checks++;
    if (seen.size() != 1 || seen[0] != 4) begin
      failures++; $display("FAIL zero_then_vec got n=%0d want one index 4", seen.size());
    end
  endtask

  task automatic test_order();
    int want[3];
    reset_dut();
    run_vec(8'b1000_1001, 0);
    checks++;
    if (seen.size() != 3 || seen[0] != 7 || seen[1] != 3 || seen[2] != 0) begin
      failures++; $display("FAIL order_first got n=%0d want 7,3,0", seen.size());
    end
    run_vec(8'b1000_1001, 0);
    checks++;
    if (seen.size() != 3 || seen[0] != 7 || seen[1] != 3 || seen[2] != 0) begin
      failures++; $display("FAIL order_second got n=%0d want 7,3,0", seen.size());
    end
    run_vec(8'b0000_1100, 0);
`ifdef ENC_RR_EN
    want = '{1, 0, 7};
`else
    want = '{7, 1, 0};
`endif
    run_vec(8'b1000_0011, 0);
    checks++;
    if (seen.size() != 3 || seen[0] != want[0] || seen[1] != want[1] || seen[2] != want[2]) begin
      failures++;
      $display("FAIL order_ptr got %0d,%0d,%0d want %0d,%0d,%0d",
               seen.size() > 0 ? seen[0] : -1, seen.size() > 1 ? seen[1] : -1,
               seen.size() > 2 ? seen[2] : -1, want[0], want[1], want[2]);
    end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    run_vec(8'hFF, 0);
    checks++;
    if (seen.size() != 8) begin
      failures++; $display("FAIL all_ones got n=%0d want 8", seen.size());
    end
    for (int i = 0; i < 6; i++) run_vec(8'($urandom), 0);
  endtask

  task automatic test_random();
    reset_dut();
    for (int i = 0; i < 40; i++) begin
      run_vec(($urandom_range(9) == 0) ? 8'h00 : 8'($urandom), 35);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_vec = '0;
    bus.out_ready = 1'b0;
    mptr = WIDTH - 1;
    test_reset();
    test_single_bit();
    test_multi_bit();
    test_stall();
    test_zero_vec();
    test_order();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
